// File: rtl/addsub_nibble_seq_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub controller.
// master = producer/consumer side, slave = controller side.
interface addsub_nibble_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, busy
    );
endinterface

// File: rtl/addsub_nibble_seq.sv
// WIDTH-bit B+A / B-A built from a single 4-bit add slice, one nibble per cycle,
// with the inter-nibble carry held in a register.
module addsub_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    addsub_nibble_seq_if.slave bus
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             sub_q, cout_q, ovf_q;

    logic             accept;
    logic             last_nib;
    logic [3:0]       nib_a, nib_b;
    logic [4:0]       slice_sum;
    logic [WIDTH-1:0] result_run;
    logic             ovf_run;

    assign accept   = (state_q == StIdle) && bus.in_valid;
    assign last_nib = (idx_q == LastIdx);

    // Nibble select, the add slice itself, and write-back into the result nibble.
    always_comb begin
        nib_a      = '0;
        nib_b      = '0;
        result_run = result_q;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IdxW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        slice_sum = {1'b0, nib_a ^ {4{sub_q}}} + {1'b0, nib_b} + {4'b0000, carry_q};
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IdxW'(i)) begin
                result_run[4*i +: 4] = slice_sum[3:0];
            end
        end
        ovf_run = sub_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (result_run[WIDTH-1] != b_q[WIDTH-1]))
                        : ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_run[WIDTH-1] != b_q[WIDTH-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_nib) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.result    = result_q;
        bus.cout      = cout_q;
        bus.overflow  = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        sub_q    <= bus.sub;
                        carry_q  <= bus.sub;  // +1 of the two's-complement negate
                        idx_q    <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                StRun: begin
                    result_q <= result_run;
                    carry_q  <= slice_sum[4];
                    if (last_nib) begin
                        cout_q <= slice_sum[4];
                        ovf_q  <= ovf_run;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed and randomized checks of addsub_nibble_seq at WIDTH=16 and WIDTH=4.
module tb_addsub_nibble_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    addsub_nibble_seq_if #(.WIDTH(16)) bus16 ();
    addsub_nibble_seq_if #(.WIDTH(4))  bus4 ();

    addsub_nibble_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    addsub_nibble_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result is {overflow, cout, result}.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        logic [16:0] sum;
        logic        ov;
        sum = {1'b0, b} + {1'b0, (s ? ~a : a)} + {16'd0, s};
        ov  = s ? ((a[15] != b[15]) && (sum[15] != b[15]))
                : ((a[15] == b[15]) && (sum[15] != b[15]));
        return {ov, sum};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic [4:0] sum;
        logic       ov;
        sum = {1'b0, b} + {1'b0, (s ? ~a : a)} + {4'd0, s};
        ov  = s ? ((a[3] != b[3]) && (sum[3] != b[3])) : ((a[3] == b[3]) && (sum[3] != b[3]));
        return {ov, sum};
    endfunction

    // Issue one op from IDLE and collect it; lat counts cycles from accept edge to out_valid.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic o, output int lat);
        bus16.a = a; bus16.b = b; bus16.sub = s; bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        bus16.a = ~a; bus16.b = ~b;
        lat = 0;
        while (!bus16.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        r = bus16.result; c = bus16.cout; o = bus16.overflow;
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output logic [3:0] r, output logic c, output logic o, output int lat);
        bus4.a = a; bus4.b = b; bus4.sub = s; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        r = bus4.result; c = bus4.cout; o = bus4.overflow;
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic        c;
        logic        o;
    } vec16_t;

    initial begin
        vec16_t      vecs[6];
        logic [15:0] r;
        logic [3:0]  r4;
        logic        c, o, seen;
        logic [17:0] m;
        logic [5:0]  m4;
        logic [15:0] ra, rb;
        logic [3:0]  ra4, rb4;
        logic        rs;
        int          lat;

        vecs[0] = '{16'h0FCD, 16'h1234, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'h0007, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[3] = '{16'h0001, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0001, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_in_ready", 32'(bus16.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check_eq("rst_busy", 32'(bus16.busy), 32'd0);
        check_eq("rst_result", 32'(bus16.result), 32'd0);
        check_eq("rst_flags", {30'd0, bus16.cout, bus16.overflow}, 32'd0);

        // Directed add/sub vectors
        foreach (vecs[i]) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].s, r, c, o, lat);
            check_eq($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].r));
            check_eq($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].c));
            check_eq($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].o));
            check_eq($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // Backpressure in DONE with a competing operand bundle offered
        bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("bp_latency", 32'(lat), 32'd4);
        bus16.a = 16'hAAAA; bus16.b = 16'h0001; bus16.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("bp_hold_result", 32'(bus16.result), 32'h3333);
            check_eq("bp_hold_valid", {30'd0, bus16.out_valid, bus16.in_ready}, 32'd2);
        end
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        check_eq("bp_release", {30'd0, bus16.out_valid, bus16.in_ready}, 32'd1);
        tick();
        bus16.in_valid = 1'b0;
        check_eq("bp_reaccept", {30'd0, bus16.busy, bus16.in_ready}, 32'd2);
        lat = 0;
        while (!bus16.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("bp_next_latency", 32'(lat), 32'd4);
        check_eq("bp_next_result", 32'(bus16.result), 32'hAAAB);
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;

        // Reset during the second RUN cycle aborts the op
        bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_state", {29'd0, bus16.in_ready, bus16.busy, bus16.out_valid}, 32'd4);
        check_eq("abort_result", 32'(bus16.result), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | bus16.out_valid;
        end
        check_eq("abort_no_pulse", 32'(seen), 32'd0);
        run16(16'h0FCD, 16'h1234, 1'b0, r, c, o, lat);
        check_eq("after_abort_result", 32'(r), 32'h2201);
        check_eq("after_abort_latency", 32'(lat), 32'd4);

        // WIDTH=4: 3 - (-7) = 10 does not fit 4-bit signed, so overflow is set
        run4(4'h9, 4'h3, 1'b1, r4, c, o, lat);
        check_eq("w4_result", 32'(r4), 32'hA);
        check_eq("w4_cout", 32'(c), 32'd0);
        check_eq("w4_ovf", 32'(o), 32'd1);
        check_eq("w4_latency", 32'(lat), 32'd1);
        for (int k = 0; k < 50; k++) begin
            ra4 = 4'($urandom); rb4 = 4'($urandom); rs = 1'($urandom);
            m4  = model4(ra4, rb4, rs);
            run4(ra4, rb4, rs, r4, c, o, lat);
            check_eq("w4_rand", {26'd0, o, c, r4}, {26'd0, m4});
        end

        // Random sweep at WIDTH=16
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            m  = model16(ra, rb, rs);
            run16(ra, rb, rs, r, c, o, lat);
            check_eq("w16_rand", {14'd0, o, c, r}, {14'd0, m});
            if (lat != 4) check_eq("w16_rand_latency", 32'(lat), 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
